sub_unit: RTL and testbench

- Self-timed run controller used as the simulation/bring-up child of the top-level wrapper.
- Only clock and reset are driven from outside.
- After reset it runs for a fixed number of cycles, then parks in DONE.
- While running it counts cycles, toggles a heartbeat, and advances a 16-bit LFSR signature. All of these are exposed as status outputs; the wrapper may leave them unconnected.

---
 rtl/sub_unit_pkg.sv | 29 ++
 rtl/sub_unit_lfsr.sv | 24 ++
 rtl/sub_unit.sv | 119 +++++++++++
 tb/tb_sub_unit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/sub_unit_pkg.sv
// Shared types and constants for the sub_unit run controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`timescale 1ns/1ps
package sub_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LFSR_W = 16;

    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bit indices of q).
    localparam int LFSR_TAP_A = 15;
    localparam int LFSR_TAP_B = 13;
    localparam int LFSR_TAP_C = 12;
    localparam int LFSR_TAP_D = 10;

    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // One LFSR step: shift left, feedback into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0],
                q[LFSR_TAP_A] ^ q[LFSR_TAP_B] ^ q[LFSR_TAP_C] ^ q[LFSR_TAP_D]};
    endfunction

endpackage

// File: rtl/sub_unit_lfsr.sv
// 16-bit Fibonacci LFSR with synchronous seed load and step enable.
// Latency: q updates on the edge where load or step is sampled high.
// Backpressure: none; step=0 holds the value, load has priority over step.
// Ports: clk, load (load seed), step (advance one), seed, q (current value).
`timescale 1ns/1ps
module sub_unit_lfsr
    import sub_unit_pkg::*;
(
    input  logic              clk,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (load) begin
            q <= seed;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/sub_unit.sv
// Self-timed run controller: runs FINISH_CYCLE cycles after reset, then parks in DONE.
// Latency: RUN starts one edge after reset release; done asserts FINISH_CYCLE edges later.
// Backpressure: none; only clk and reset_l are inputs.
// Ports: clk, reset_l (sync, ACTIVE-HIGH despite the name), cycle_count, running,
//        done, done_pulse, heartbeat, lfsr_q.
`timescale 1ns/1ps
module sub_unit
    import sub_unit_pkg::*;
#(
    parameter int                CNT_W        = 32,
    parameter int                FINISH_CYCLE = 10,
    parameter int                HB_PERIOD    = 4,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = LFSR_DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              reset_l,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              running,
    output logic              done,
    output logic              done_pulse,
    output logic              heartbeat,
    output logic [LFSR_W-1:0] lfsr_q
);

    // An all-zero seed would lock the LFSR up, so fall back to 1.
    localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? 16'h0001 : LFSR_SEED;

    // Divider needs at least one bit even when HB_PERIOD is 1.
    localparam int               HB_W    = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
    localparam logic [HB_W-1:0]  HB_LAST = HB_W'(HB_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FINISH_CYCLE - 1);

    state_t          state;
    state_t          state_nxt;
    logic [HB_W-1:0] hb_div;
    logic            in_run;
    logic            last_run;

    assign in_run   = (state == RUN);
    assign last_run = in_run && (cycle_count == CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset_l) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = RUN;
            RUN:     if (last_run) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        running = 1'b0;
        done    = 1'b0;
        case (state)
            RUN:     running = 1'b1;
            DONE:    done    = 1'b1;
            default: ;
        endcase
    end

    // Counter, heartbeat divider and done pulse. Only RUN edges advance
    // anything, so everything freezes on entry to DONE.
    always_ff @(posedge clk) begin
        if (reset_l) begin
            cycle_count <= '0;
            hb_div      <= '0;
            heartbeat   <= 1'b0;
            done_pulse  <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if (in_run) begin
                cycle_count <= cycle_count + 1'b1;
                // Toggling at the wrap makes heartbeat flip whenever the new
                // cycle_count is a multiple of HB_PERIOD.
                if (hb_div == HB_LAST) begin
                    hb_div    <= '0;
                    heartbeat <= ~heartbeat;
                end else begin
                    hb_div <= hb_div + 1'b1;
                end
                if (last_run) begin
                    done_pulse <= 1'b1;
                end
            end
        end
    end

    sub_unit_lfsr u_lfsr (
        .clk  (clk),
        .load (reset_l),
        .step (in_run),
        .seed (SEED_EFF),
        .q    (lfsr_q)
    );

`ifndef SYNTHESIS
    // Announce completion on the edge that enters DONE; the LFSR value shown
    // is the one it takes on that same edge.
    always @(posedge clk) begin
        if (!reset_l && last_run) begin
            $display("[%0t] sub_unit finished, cycles=%0d sig=%h",
                     $time, FINISH_CYCLE, lfsr_next(lfsr_q));
        end
    end
`endif

endmodule

// File: tb/tb_sub_unit.sv
// Directed self-checking bench for sub_unit with default parameters.
// Latency: n/a (bench).
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_sub_unit;

    logic        clk;
    logic        reset_l;
    logic [31:0] cycle_count;
    logic        running;
    logic        done;
    logic        done_pulse;
    logic        heartbeat;
    logic [15:0] lfsr_q;

    int n_cmp;
    int n_bad;

    sub_unit #(
        .CNT_W        (32),
        .FINISH_CYCLE (10),
        .HB_PERIOD    (4),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk         (clk),
        .reset_l     (reset_l),
        .cycle_count (cycle_count),
        .running     (running),
        .done        (done),
        .done_pulse  (done_pulse),
        .heartbeat   (heartbeat),
        .lfsr_q      (lfsr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR step, written from the polynomial taps 15/13/12/10.
    function automatic logic [15:0] ref_step(input logic [15:0] q);
        logic fb;
        fb = q[15] ^ q[13] ^ q[12] ^ q[10];
        return {q[14:0], fb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1ns later, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".cycle_count"}, cycle_count, 32'd0);
        chk({tag, ".running"},     {31'd0, running},    32'd0);
        chk({tag, ".done"},        {31'd0, done},       32'd0);
        chk({tag, ".done_pulse"},  {31'd0, done_pulse}, 32'd0);
        chk({tag, ".heartbeat"},   {31'd0, heartbeat},  32'd0);
        chk({tag, ".lfsr_q"},      {16'd0, lfsr_q},     32'h0000ACE1);
    endtask

    // Release reset and follow the run for stop_at RUN edges.
    // Returns the model LFSR value reached.
    task automatic run_from_release(input string tag, input int stop_at,
                                    output logic [15:0] sig);
        logic [15:0] m_lfsr;
        logic        m_hb;
        m_lfsr = 16'hACE1;
        m_hb   = 1'b0;
        reset_l = 1'b0;
        tick();
        chk({tag, ".first.running"}, {31'd0, running}, 32'd1);
        chk({tag, ".first.count"},   cycle_count, 32'd0);
        chk({tag, ".first.lfsr"},    {16'd0, lfsr_q}, {16'd0, m_lfsr});
        for (int k = 1; k <= stop_at; k++) begin
            tick();
            m_lfsr = ref_step(m_lfsr);
            if (k % 4 == 0) m_hb = ~m_hb;
            chk($sformatf("%s.k%0d.count", tag, k), cycle_count, k);
            chk($sformatf("%s.k%0d.lfsr", tag, k), {16'd0, lfsr_q}, {16'd0, m_lfsr});
            chk($sformatf("%s.k%0d.hb", tag, k), {31'd0, heartbeat}, {31'd0, m_hb});
            chk($sformatf("%s.k%0d.running", tag, k), {31'd0, running}, (k < 10) ? 32'd1 : 32'd0);
            chk($sformatf("%s.k%0d.done", tag, k), {31'd0, done}, (k == 10) ? 32'd1 : 32'd0);
            chk($sformatf("%s.k%0d.pulse", tag, k), {31'd0, done_pulse}, (k == 10) ? 32'd1 : 32'd0);
        end
        sig = m_lfsr;
    endtask

    initial begin
        logic [15:0] sig;
        n_cmp   = 0;
        n_bad   = 0;
        reset_l = 1'b1;

        // Reset held for three edges.
        repeat (3) tick();
        chk_reset_vals("rst");

        // Full run; hand-computed LFSR points for the first two steps.
        reset_l = 1'b0;
        tick();
        chk("run.e1.running", {31'd0, running}, 32'd1);
        chk("run.e1.count",   cycle_count, 32'd0);
        tick();
        chk("run.e2.lfsr", {16'd0, lfsr_q}, 32'h000059C3);
        tick();
        chk("run.e3.lfsr", {16'd0, lfsr_q}, 32'h0000B387);

        // Restart from reset and follow the whole run against the model.
        reset_l = 1'b1;
        tick();
        chk_reset_vals("rst2");
        run_from_release("run", 10, sig);

        // Parked in DONE: everything frozen, pulse gone.
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("park%0d.count", k), cycle_count, 32'd10);
            chk($sformatf("park%0d.lfsr", k),  {16'd0, lfsr_q}, {16'd0, sig});
            chk($sformatf("park%0d.hb", k),    {31'd0, heartbeat}, 32'd0);
            chk($sformatf("park%0d.done", k),  {31'd0, done}, 32'd1);
            chk($sformatf("park%0d.pulse", k), {31'd0, done_pulse}, 32'd0);
        end

        // Reset from DONE, then abort a run mid-way at cycle_count=5.
        reset_l = 1'b1;
        tick();
        chk_reset_vals("rst3");
        run_from_release("abort", 5, sig);
        reset_l = 1'b1;
        tick();
        chk_reset_vals("midrst");

        // The repeated run must match the first one exactly.
        run_from_release("rerun", 10, sig);
        tick();
        chk("rerun.after.pulse", {31'd0, done_pulse}, 32'd0);
        chk("rerun.after.count", cycle_count, 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
